spi_flash_writer: RTL and testbench

- SPI flash initiator that erases 4 KB sectors and programs pages of the external W25Q-family flash. It is the write-direction counterpart of the cart's flash-read path.
- Used to persist cartridge save RAM back to flash.
- Takes a command/length request plus a byte stream and performs the full sequence: Write Enable (0x06), then Sector Erase (0x20) or Page Program (0x02), then Read Status (0x05) polling until WIP clears.
- Shares the SPI pins with the reader through an external mux. The mux is owned by the top level.

---
 rtl/spi_flash_writer.sv | 141 ++++++++++++++
 tb/tb_spi_flash_writer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_writer.sv
// spi_flash_writer: W25Q sector-erase / page-program sequencer with WREN, command, data and WIP polling
module spi_flash_writer #(
  parameter int SCK_HALF = 2,
  parameter int CS_GAP = 4,
  parameter logic [23:0] POLL_LIMIT = 24'd4000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] addr,
  input  logic [8:0]  len,
  input  logic        erase,
  input  logic        go,
  output logic        rdy,
  input  logic [7:0]  wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic        done,
  output logic        err,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        spi_cs_n,
  output logic        spi_clk
);
  typedef enum logic [3:0] {IDLE, WREN, GAP_W, CMD, DATA, GAP_C, POLL, GAP_P, FINISH} state_t;
  localparam int DW = $clog2(SCK_HALF + 1);
  localparam int GW = $clog2(CS_GAP + 1);
  state_t state, state_n;
  logic [23:0] a_r, poll_cnt;
  logic [8:0] len_r, byte_cnt;
  logic [7:0] sh, rx, load_byte;
  logic [2:0] bit_cnt;
  logic [DW-1:0] div;
  logic [GW-1:0] gap_cnt;
  logic er_r, loaded, sck, cs_n, rd, fail;
  logic tick, byte_end, accept, ovf, bad, load, active, gap_end, stat_end, poll_stop;
  assign tick = div == DW'(SCK_HALF - 1);
  assign byte_end = loaded && tick && sck && bit_cnt == 3'd7;
  assign rdy = state == IDLE || state == FINISH;
  assign accept = go && rdy;
  assign ovf = 10'(addr[7:0]) + 10'(len) > 10'd256;
  assign bad = !erase && (len == 9'd0 || ovf);
  assign gap_end = gap_cnt == GW'(CS_GAP - 1);
  assign stat_end = state == POLL && byte_end && rd;
  assign poll_stop = !rx[0] || poll_cnt >= POLL_LIMIT - 24'd1;
  assign wr_ready = state == DATA && byte_cnt < len_r && (!loaded || byte_end);
  assign active = state_n inside {WREN, CMD, DATA, POLL};
  assign done = state == FINISH;
  assign err = done && fail;
  assign spi_clk = sck;
  assign spi_cs_n = cs_n;
  assign spi_mosi = sh[7];
  // Each active state leaves only once its last byte has fully shifted, so CS rises a cycle after the final SCK fall.
  always_comb begin
    state_n = state;
    load = 1'b0;
    load_byte = 8'h00;
    case (state)
      IDLE, FINISH: state_n = accept ? (bad ? FINISH : WREN) : IDLE;
      WREN: begin
        load = !loaded && byte_cnt == 9'd0;
        load_byte = 8'h06;
        if (byte_cnt == 9'd1 && !loaded) state_n = GAP_W;
      end
      CMD: begin
        load = byte_cnt < 9'd4 && (!loaded || byte_end);
        load_byte = byte_cnt == 9'd0 ? (er_r ? 8'h20 : 8'h02) :
                    byte_cnt == 9'd1 ? a_r[23:16] : byte_cnt == 9'd2 ? a_r[15:8] : a_r[7:0];
        if (byte_cnt == 9'd4 && !loaded) state_n = er_r ? GAP_C : DATA;
      end
      DATA: begin
        load = wr_valid && wr_ready;
        load_byte = wr_data;
        if (byte_cnt == len_r && !loaded) state_n = GAP_C;
      end
      POLL: begin
        load = byte_cnt == 9'd0 ? !loaded : byte_end && (!rd || !poll_stop);
        load_byte = byte_cnt == 9'd0 ? 8'h05 : 8'h00;
        if (byte_cnt != 9'd0 && !loaded) state_n = GAP_P;
      end
      GAP_W: if (gap_end) state_n = CMD;
      GAP_C: if (gap_end) state_n = POLL;
      GAP_P: if (gap_end) state_n = FINISH;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cs_n <= 1'b1;
      sck <= 1'b0;
      sh <= 8'h00;
      rx <= 8'h00;
      loaded <= 1'b0;
      bit_cnt <= 3'd0;
      div <= '0;
      gap_cnt <= '0;
      byte_cnt <= 9'd0;
      poll_cnt <= 24'd0;
      rd <= 1'b0;
      fail <= 1'b0;
      a_r <= 24'd0;
      len_r <= 9'd0;
      er_r <= 1'b0;
    end else begin
      state <= state_n;
      cs_n <= !active;
      byte_cnt <= state_n != state ? 9'd0 : byte_cnt + 9'(load && byte_cnt != 9'h1ff);
      gap_cnt <= state_n != state ? '0 : gap_cnt + GW'(!gap_end);
      rd <= state_n == state && (rd || (load && state == POLL && byte_cnt != 9'd0));
      if (accept) begin
        a_r <= addr;
        len_r <= len;
        er_r <= erase;
        fail <= !erase && ovf;
        poll_cnt <= 24'd0;
      end
      if (stat_end) begin
        poll_cnt <= poll_cnt + 24'(poll_cnt != POLL_LIMIT);
        fail <= rx[0];
      end
      if (load) begin
        sh <= load_byte;
        bit_cnt <= 3'd0;
        div <= '0;
        sck <= 1'b0;
        loaded <= 1'b1;
      end else if (loaded) begin
        div <= tick ? '0 : div + DW'(1);
        if (tick) begin
          sck <= !sck;
          if (!sck) rx <= {rx[6:0], spi_miso};
          else if (bit_cnt == 3'd7) loaded <= 1'b0;
          else begin
            bit_cnt <= bit_cnt + 3'd1;
            sh <= {sh[6:0], 1'b0};
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_spi_flash_writer.sv
// tb_spi_flash_writer: directed checks of erase/program/poll sequences against a small SPI flash model
module tb_spi_flash_writer;
  logic clk = 1'b0;
  logic rst, go, erase, wr_valid, spi_miso, rdy, wr_ready, done, err, spi_mosi, spi_cs_n, spi_clk;
  logic [23:0] addr;
  logic [8:0] len;
  logic [7:0] wr_data;
  int total = 0, bad_n = 0;
  logic [7:0] dat [0:3];
  logic [7:0] mb[$];
  int wins[$], gaps[$];
  int win_bits = 0, cs_hi = 0, wip_n = 0, k, hs_cnt = 0, done_cnt = 0;
  logic prev_cs = 1'b1, prev_sck = 1'b0;
  logic [7:0] sr = 8'h00, sb;
  int r_t, r_over, r_stall_bad, r_st;
  logic r_err, r_to;

  spi_flash_writer #(.SCK_HALF(2), .CS_GAP(4), .POLL_LIMIT(24'd8)) dut (
    .clk(clk), .rst(rst), .addr(addr), .len(len), .erase(erase), .go(go), .rdy(rdy),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready), .done(done), .err(err),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_cs_n(spi_cs_n), .spi_clk(spi_clk)
  );

  always #5 clk = ~clk;

  // Flash model: first wip_n status bytes of a window report WIP=1 (0x03), later ones 0x02.
  always_comb begin
    k = win_bits / 8 - 1;
    sb = k < wip_n ? 8'h03 : 8'h02;
    spi_miso = sb[3'(7 - win_bits % 8)];
  end

  always @(negedge clk) begin
    if (!spi_cs_n && prev_cs) gaps.push_back(cs_hi);
    if (spi_cs_n && !prev_cs) wins.push_back(win_bits);
    cs_hi <= spi_cs_n ? cs_hi + 1 : 0;
    if (!spi_cs_n && prev_cs) win_bits <= 0;
    else if (!spi_cs_n && spi_clk && !prev_sck) begin
      win_bits <= win_bits + 1;
      sr <= {sr[6:0], spi_mosi};
      if (win_bits % 8 == 7) mb.push_back({sr[6:0], spi_mosi});
    end
    prev_cs <= spi_cs_n;
    prev_sck <= spi_clk;
  end

  always @(posedge clk) begin
    hs_cnt <= hs_cnt + int'(wr_valid && wr_ready);
    done_cnt <= done_cnt + int'(done);
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) else begin
      bad_n++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run(input logic [23:0] a, input logic [8:0] l, input logic e, input int stall_n);
    int idx;
    idx = 0;
    r_st = stall_n;
    r_t = 0;
    r_over = 0;
    r_stall_bad = 0;
    @(negedge clk);
    addr = a;
    len = l;
    erase = e;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    while (!done && r_t < 20000) begin
      wr_valid = idx < int'(l) && !(idx == 2 && r_st > 0);
      wr_data = idx < 4 ? dat[idx] : 8'h00;
      if (idx == 2 && r_st > 0 && wr_ready) begin
        if (r_st < stall_n && (spi_clk || spi_cs_n)) r_stall_bad++;
        r_st--;
      end
      if (wr_ready && idx >= int'(l)) r_over++;
      if (wr_valid && wr_ready) idx++;
      @(negedge clk);
      r_t++;
    end
    wr_valid = 1'b0;
    r_to = !done;
    r_err = err;
  endtask

  task automatic post(input string tag, input logic exp_err, input int dc0);
    chk({tag, "_timeout"}, int'(r_to), 0);
    chk({tag, "_err"}, int'(r_err), int'(exp_err));
    @(negedge clk);
    chk({tag, "_pulse"}, int'({done, err}), 0);
    chk({tag, "_ndone"}, done_cnt - dc0, 1);
    chk({tag, "_rdy"}, int'(rdy), 1);
  endtask

  task automatic check_seq(input string tag, input logic [23:0] a, input logic e, input int nd, input int ns,
                           input int bm, input int wm);
    logic [7:0] x[$];
    x = {8'h06, e ? 8'h20 : 8'h02, a[23:16], a[15:8], a[7:0]};
    for (int i = 0; i < nd; i++) x.push_back(dat[i]);
    x.push_back(8'h05);
    for (int i = 0; i < ns; i++) x.push_back(8'h00);
    chk({tag, "_nbytes"}, mb.size() - bm, x.size());
    for (int i = 0; i < x.size() && bm + i < mb.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), int'(mb[bm + i]), int'(x[i]));
    chk({tag, "_nwin"}, wins.size() - wm, 3);
    if (wins.size() >= wm + 3) begin
      chk({tag, "_win_wren"}, wins[wm], 8);
      chk({tag, "_win_cmd"}, wins[wm + 1], 8 * (4 + nd));
      chk({tag, "_win_poll"}, wins[wm + 2], 8 * (1 + ns));
      chk({tag, "_gap1"}, int'(gaps[wm + 1] >= 4), 1);
      chk({tag, "_gap2"}, int'(gaps[wm + 2] >= 4), 1);
    end
  endtask

  initial begin
    int bm, wm, dc, hs0, t;
    rst = 1'b1;
    go = 1'b0;
    addr = 24'd0;
    len = 9'd0;
    erase = 1'b0;
    wr_data = 8'h00;
    wr_valid = 1'b0;
    dat[0] = 8'hA5;
    dat[1] = 8'h5A;
    dat[2] = 8'h00;
    dat[3] = 8'hFF;
    repeat (3) @(negedge clk);
    chk("rst_rdy", int'(rdy), 1);
    chk("rst_done_err", int'({done, err}), 0);
    chk("rst_wr_ready", int'(wr_ready), 0);
    chk("rst_spi", int'({spi_cs_n, spi_clk, spi_mosi}), 4);
    rst = 1'b0;

    wip_n = 3; bm = mb.size(); wm = wins.size(); dc = done_cnt;
    run(24'h100000, 9'd0, 1'b1, 0);
    post("erase", 1'b0, dc);
    check_seq("erase", 24'h100000, 1'b1, 0, 4, bm, wm);

    wip_n = 1; bm = mb.size(); wm = wins.size(); dc = done_cnt; hs0 = hs_cnt;
    run(24'h100010, 9'd4, 1'b0, 0);
    post("prog", 1'b0, dc);
    chk("prog_hs", hs_cnt - hs0, 4);
    chk("prog_over", r_over, 0);
    check_seq("prog", 24'h100010, 1'b0, 4, 2, bm, wm);

    wip_n = 1; bm = mb.size(); wm = wins.size(); dc = done_cnt; hs0 = hs_cnt;
    run(24'h100010, 9'd4, 1'b0, 20);
    post("stall", 1'b0, dc);
    chk("stall_hs", hs_cnt - hs0, 4);
    chk("stall_left", r_st, 0);
    chk("stall_sck_cs", r_stall_bad, 0);
    check_seq("stall", 24'h100010, 1'b0, 4, 2, bm, wm);

    wm = wins.size(); dc = done_cnt;
    run(24'h1000F0, 9'd32, 1'b0, 0);
    chk("ovf_latency", r_t, 0);
    post("ovf", 1'b1, dc);
    chk("ovf_no_cs", gaps.size() - wm, 0);

    wm = wins.size(); dc = done_cnt;
    run(24'h100010, 9'd0, 1'b0, 0);
    chk("len0_latency", r_t, 0);
    post("len0", 1'b0, dc);
    chk("len0_no_cs", gaps.size() - wm, 0);

    wip_n = 1000; bm = mb.size(); wm = wins.size(); dc = done_cnt;
    run(24'h100000, 9'd0, 1'b1, 0);
    post("tmo", 1'b1, dc);
    check_seq("tmo", 24'h100000, 1'b1, 0, 8, bm, wm);

    wip_n = 0; bm = mb.size(); dc = done_cnt;
    @(negedge clk);
    addr = 24'h100000;
    erase = 1'b1;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    t = 0;
    while (mb.size() < bm + 2 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("rst_reach_addr", mb.size() - bm, 2);
    repeat (6) @(negedge clk);
    chk("rst_mid_cs", int'(spi_cs_n), 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_cs_high", int'(spi_cs_n), 1);
    chk("rst_mid_rdy", int'(rdy), 1);
    repeat (20) @(negedge clk);
    chk("rst_mid_no_done", done_cnt - dc, 0);

    wip_n = 2; bm = mb.size(); wm = wins.size(); dc = done_cnt;
    run(24'h100000, 9'd0, 1'b1, 0);
    post("after_rst", 1'b0, dc);
    check_seq("after_rst", 24'h100000, 1'b1, 0, 3, bm, wm);

    $display("test done: total=%0d bad=%0d", total, bad_n);
    $finish;
  end
endmodule
